// File: rtl/sn_network_ctrlr.sv
// -----------------------------------------------------------------------------
// sn_network_ctrlr
//   Timestep sequencer for the spiking network. It sits directly upstream of
//   the API controller. Each run clears neuron state once. Then, for every
//   timestep, it holds an integrate phase for a fixed number of cycles. After
//   that it holds nc_transmit until the API controller reports api_nc_done, or
//   until the transmit watchdog expires. A one-cycle gap follows each
//   transmit window so that every window starts with a fresh rising edge.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   start        in   run request, honoured only while idle
//   abort        in   abandon the current run, return to idle without done
//   num_ts       in   timesteps for this run, clamped to P_MAX_TS, sampled at start
//   api_nc_done  in   API controller finished the current transmit period
//   nc_clear     out  one-cycle pulse: neurons clear membrane/refractory state
//   nc_integrate out  neurons integrate/leak while high
//   nc_transmit  out  level to the API controller for the whole transmit period
//   busy         out  sequencer is not idle
//   done         out  one-cycle pulse at normal run completion
//   ts_cnt       out  0-based index of the current timestep
//   timeout_err  out  sticky: a transmit period hit the watchdog limit
// -----------------------------------------------------------------------------
module sn_network_ctrlr #(
    parameter int P_MAX_TS       = 16,
    parameter int P_TS_W         = $clog2(P_MAX_TS + 1),
    parameter int P_INTEG_CYCLES = 4,
    parameter int P_XMIT_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [P_TS_W-1:0] num_ts,
    input  logic              api_nc_done,
    output logic              nc_clear,
    output logic              nc_integrate,
    output logic              nc_transmit,
    output logic              busy,
    output logic              done,
    output logic [P_TS_W-1:0] ts_cnt,
    output logic              timeout_err
);

    localparam int IC_W = $clog2(P_INTEG_CYCLES + 1);
    localparam int TO_W = $clog2(P_XMIT_TIMEOUT + 1);

    localparam logic [IC_W-1:0]   INTEG_LOAD = IC_W'(P_INTEG_CYCLES - 1);
    localparam logic [TO_W-1:0]   XMIT_LAST  = TO_W'(P_XMIT_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   XMIT_SAT   = '1;
    localparam logic [P_TS_W-1:0] MAX_TS     = P_TS_W'(P_MAX_TS);
    localparam logic [P_TS_W-1:0] TS_ONE     = P_TS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_INTEG,
        S_XMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [P_TS_W-1:0] n_ts;       // clamped timestep count latched at start
    logic [IC_W-1:0]   integ_cnt;  // remaining INTEG cycles after the current one
    logic [TO_W-1:0]   xmit_cnt;   // XMIT cycles already completed
    logic              set_err;
    logic              last_ts;

    // Only reached in GAP, where n_ts is at least 1, so n_ts - 1 cannot underflow there.
    assign last_ts = (ts_cnt == (n_ts - TS_ONE));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            S_IDLE:  if (start) next_state = S_CLEAR;
            S_CLEAR: next_state = (n_ts == '0) ? S_DONE : S_INTEG;
            S_INTEG: if (integ_cnt == '0) next_state = S_XMIT;
            S_XMIT: begin
                if (api_nc_done) begin
                    next_state = S_GAP;
                end else if (xmit_cnt >= XMIT_LAST) begin
                    // This cycle is the last one the watchdog allows.
                    next_state = S_GAP;
                    set_err    = 1'b1;
                end
            end
            S_GAP:   next_state = last_ts ? S_DONE : S_INTEG;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // abort overrides every transition, including a watchdog expiry.
        if (abort) begin
            next_state = S_IDLE;
            set_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_ts        <= '0;
            ts_cnt      <= '0;
            timeout_err <= 1'b0;
            integ_cnt   <= INTEG_LOAD;
            xmit_cnt    <= '0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                n_ts        <= (num_ts > MAX_TS) ? MAX_TS : num_ts;
                ts_cnt      <= '0;
                timeout_err <= 1'b0;
            end

            if (state == S_GAP && next_state == S_INTEG) begin
                ts_cnt <= ts_cnt + TS_ONE;
            end

            if (set_err) begin
                timeout_err <= 1'b1;
            end

            // The counter is preloaded outside INTEG, so each INTEG entry sees a full count.
            if (state == S_INTEG && integ_cnt != '0) begin
                integ_cnt <= integ_cnt - IC_W'(1);
            end else begin
                integ_cnt <= INTEG_LOAD;
            end

            // Clear outside XMIT, count inside it. The count saturates and never wraps.
            if (state == S_XMIT) begin
                if (xmit_cnt != XMIT_SAT) begin
                    xmit_cnt <= xmit_cnt + TO_W'(1);
                end
            end else begin
                xmit_cnt <= '0;
            end
        end
    end

    // Moore outputs: decoded only from registered state.
    always_comb begin
        nc_clear     = (state == S_CLEAR);
        nc_integrate = (state == S_INTEG);
        nc_transmit  = (state == S_XMIT);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
    end

endmodule

// File: tb/tb_sn_network_ctrlr.sv
// -----------------------------------------------------------------------------
// tb_sn_network_ctrlr
//   Self-checking bench for sn_network_ctrlr. It uses a short watchdog limit of
//   8 so that the timeout case stays short. A cycle-by-cycle vector table
//   covers the tied-high api_nc_done run. Hand-written sequences cover the
//   nominal run, the timeout run, abort and ignored start, the num_ts bounds,
//   and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_sn_network_ctrlr;

    localparam int TS_W    = 5;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TS_W-1:0] num_ts = '0;
    logic            api_nc_done = 1'b0;
    logic            nc_clear, nc_integrate, nc_transmit, busy, done, timeout_err;
    logic [TS_W-1:0] ts_cnt;

    int checks = 0;
    int errors = 0;

    sn_network_ctrlr #(
        .P_MAX_TS      (16),
        .P_TS_W        (TS_W),
        .P_INTEG_CYCLES(4),
        .P_XMIT_TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_ts      (num_ts),
        .api_nc_done (api_nc_done),
        .nc_clear    (nc_clear),
        .nc_integrate(nc_integrate),
        .nc_transmit (nc_transmit),
        .busy        (busy),
        .done        (done),
        .ts_cnt      (ts_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog");
    end

    // Output word: {clear, integrate, transmit, busy, done, ts_cnt[4:0], timeout_err}
    function automatic logic [31:0] pk(input bit c, input bit i, input bit x, input bit b,
                                       input bit d, input int ts, input bit e);
        logic [4:0] t5;
        t5 = ts[4:0];
        return {21'b0, c, i, x, b, d, t5, e};
    endfunction

    function automatic logic [31:0] obs();
        return {21'b0, nc_clear, nc_integrate, nc_transmit, busy, done, ts_cnt, timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        num_ts = n[TS_W-1:0];
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("clear", obs(), pk(1, 0, 0, 1, 0, 0, 0));
    endtask

    // Four INTEG cycles for timestep t. Drops start after the first edge.
    task automatic integ_phase(input int t, input bit e);
        int ok = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            if (obs() === pk(0, 1, 0, 1, 0, t, e)) ok++;
        end
        check($sformatf("integ_len ts%0d", t), ok, 4);
    endtask

    // hold > 0: api_nc_done is raised during XMIT cycle 'hold'.
    // hold == 0: api_nc_done stays low and the watchdog ends the window.
    task automatic xmit_phase(input int t, input int hold, input bit e_in, input bit e_out);
        int ok = 0;
        int len;
        len = (hold > 0) ? hold : TIMEOUT;
        api_nc_done = 1'b0;
        for (int k = 1; k <= len; k++) begin
            step();
            if (obs() === pk(0, 0, 1, 1, 0, t, e_in)) ok++;
            if (k == hold) api_nc_done = 1'b1;
        end
        check($sformatf("xmit_len ts%0d", t), ok, len);
        step();
        api_nc_done = 1'b0;
        check($sformatf("gap ts%0d", t), obs(), pk(0, 0, 0, 1, 0, t, e_out));
    endtask

    typedef struct {
        logic            rst;
        logic            start;
        logic            abort;
        logic [TS_W-1:0] num_ts;
        logic            api;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit s, input bit a, input int n, input bit api,
                           input logic [31:0] exp);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.num_ts = n[TS_W-1:0]; v.api = api; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset, then num_ts=2 with api_nc_done tied high: each XMIT is one cycle.
        // The run lasts 14 cycles from CLEAR through DONE.
        add_vec(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        add_vec(0, 1, 0, 2, 1, pk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 2, 1, pk(0, 1, 0, 1, 0, 0, 0));
        add_vec(0, 0, 0, 2, 1, pk(0, 0, 1, 1, 0, 0, 0));
        add_vec(0, 0, 0, 2, 1, pk(0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 2, 1, pk(0, 1, 0, 1, 0, 1, 0));
        add_vec(0, 0, 0, 2, 1, pk(0, 0, 1, 1, 0, 1, 0));
        add_vec(0, 0, 0, 2, 1, pk(0, 0, 0, 1, 0, 1, 0));
        add_vec(0, 0, 0, 2, 1, pk(0, 0, 0, 1, 1, 1, 0));
        add_vec(0, 0, 0, 2, 0, pk(0, 0, 0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            num_ts = vecs[i].num_ts; api_nc_done = vecs[i].api;
            step();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end
        start = 1'b0; api_nc_done = 1'b0; rst = 1'b0;

        // Nominal run: 3 timesteps, done raised in XMIT cycle 6. num_ts changes mid-run.
        start_run(3);
        num_ts = 5'd7;
        for (int t = 0; t < 3; t++) begin
            integ_phase(t, 0);
            xmit_phase(t, 6, 0, 0);
        end
        step(); check("nom_done", obs(), pk(0, 0, 0, 1, 1, 2, 0));
        step(); check("nom_idle", obs(), pk(0, 0, 0, 0, 0, 2, 0));
        step(); check("nom_single_done", obs(), pk(0, 0, 0, 0, 0, 2, 0));

        // Timeout: XMIT lasts exactly 8 cycles and sets the sticky error. done still pulses.
        start_run(1);
        integ_phase(0, 0);
        xmit_phase(0, 0, 0, 1);
        step(); check("to_done", obs(), pk(0, 0, 0, 1, 1, 0, 1));
        step(); check("to_sticky", obs(), pk(0, 0, 0, 0, 0, 0, 1));
        start_run(1);  // the new start clears timeout_err
        abort = 1'b1; step(); abort = 1'b0;
        check("to_abort_idle", obs(), pk(0, 0, 0, 0, 0, 0, 0));

        // Ignored start and num_ts change during INTEG, then abort in the XMIT of ts 1.
        start_run(3);
        start = 1'b1; num_ts = 5'd1;
        integ_phase(0, 0);
        xmit_phase(0, 2, 0, 0);
        integ_phase(1, 0);
        step(); check("ab_xmit", obs(), pk(0, 0, 1, 1, 0, 1, 0));
        abort = 1'b1; step(); abort = 1'b0;
        check("ab_next", obs(), pk(0, 0, 0, 0, 0, 1, 0));
        step(); check("ab_no_done", obs(), pk(0, 0, 0, 0, 0, 1, 0));
        start = 1'b1; abort = 1'b1; num_ts = 5'd2;
        step(); start = 1'b0; abort = 1'b0;
        check("ab_start_idle", obs(), pk(0, 0, 0, 0, 0, 1, 0));

        // num_ts=0: CLEAR goes straight to DONE.
        start_run(0);
        step(); check("zero_done", obs(), pk(0, 0, 0, 1, 1, 0, 0));
        step(); check("zero_idle", obs(), pk(0, 0, 0, 0, 0, 0, 0));

        // num_ts above the maximum clamps to 16 timesteps.
        start_run(19);
        for (int t = 0; t < 16; t++) begin
            integ_phase(t, 0);
            xmit_phase(t, 1, 0, 0);
        end
        step(); check("max_done", obs(), pk(0, 0, 0, 1, 1, 15, 0));
        step(); check("max_idle", obs(), pk(0, 0, 0, 0, 0, 15, 0));

        // Reset held 3 cycles during the XMIT of ts 1, after a timeout in ts 0.
        start_run(3);
        integ_phase(0, 0);
        xmit_phase(0, 0, 0, 1);
        integ_phase(1, 1);
        step(); check("rst_pre", obs(), pk(0, 0, 1, 1, 0, 1, 1));
        rst = 1'b1;
        step(); check("rst_first", obs(), pk(0, 0, 0, 0, 0, 0, 0));
        step();
        step(); check("rst_held", obs(), pk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(); check("rst_release", obs(), pk(0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
